mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single core memory port between instruction fetch (IF) and load/store unit (LSU).
//  One outstanding bus transaction at a time. LSU has priority, with a starvation guard so fetch always progresses.
//  IF redirects (branch/exception jump) flush an in-flight fetch: its response is dropped.
//  Sits between if_stage/mem_stage and the bus bridge.
// PARAMETERS
//  ADDR_W        64   address width
//  DATA_W        64   data width; strobe width is DATA_W/8
//  STARVE_LIMIT  4    max consecutive LSU grants while if_req is pending before IF is forced to win
//  TIMEOUT       255  max cycles in RESP before an error response is generated (8-bit counter)
// PORTS
//  clk         in   1         clock
//  rst         in   1         synchronous reset, active-high
//  if_req      in   1         fetch request; held until if_gnt
//  if_addr     in   ADDR_W    fetch address
//  if_flush    in   1         redirect; drop any in-flight fetch response
//  if_gnt      out  1         1-cycle pulse: fetch request captured
//  if_rvalid   out  1         1-cycle pulse: fetch data valid
//  if_rdata    out  DATA_W    fetch data; valid with if_rvalid
//  if_err      out  1         fetch bus error/timeout; valid with if_rvalid
//  lsu_req     in   1         LSU request; held until lsu_gnt
//  lsu_addr    in   ADDR_W    LSU address
//  lsu_wen     in   1         1 = write, 0 = read
//  lsu_wdata   in   DATA_W    write data
//  lsu_wmask   in   DATA_W/8  byte strobes
//  lsu_gnt     out  1         1-cycle pulse: LSU request captured
//  lsu_rvalid  out  1         1-cycle pulse: read data valid or write acknowledged
//  lsu_rdata   out  DATA_W    read data
//  lsu_err     out  1         LSU bus error/timeout; valid with lsu_rvalid
//  bus_valid   out  1         request valid to bus
//  bus_addr    out  ADDR_W    registered request address
//  bus_wen     out  1         registered write enable (0 for fetch)
//  bus_wdata   out  DATA_W    registered write data
//  bus_wmask   out  DATA_W/8  registered strobes (0 for fetch)
//  bus_ready   in   1         bus accepts when bus_valid & bus_ready
//  bus_rvalid  in   1         bus response
//  bus_rdata   in   DATA_W    response data
//  bus_err     in   1         response error
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; owner, flushed flag, starve and timeout counters cleared.
//    Reset mid-transaction abandons it: bus_valid is 0 after the reset edge; no rvalid is issued for it.
//  - FSM IDLE -> REQ -> RESP -> IDLE.
//  - IDLE: if any req, select the owner, register addr/wen/wdata/wmask into bus_*, pulse xx_gnt this cycle, go to REQ.
//    Selection: LSU wins unless starve_cnt == STARVE_LIMIT and if_req=1.
//  - starve_cnt: +1 on an LSU grant while if_req=1 (saturating); cleared on any IF grant.
//  - REQ: bus_valid=1 with stable fields; on bus_ready go to RESP (bus_valid=0 next cycle).
//  - RESP: on bus_rvalid, pulse the owner's rvalid with rdata/err, go to IDLE.
//    Min latency: gnt at T, bus_valid at T+1, rvalid at the bus_rvalid cycle. Next grant no earlier than the cycle after rvalid.
//  - Timeout: counter starts at 0 on entering RESP and increments each RESP cycle.
//    When it reaches TIMEOUT without bus_rvalid: pulse owner rvalid with err=1, rdata=0, go to IDLE.
//    A later stray bus_rvalid is ignored in IDLE.
//  - Flush: if_flush=1 while the owner is IF (REQ or RESP, or the same IDLE cycle as if_gnt) sets the flushed flag.
//    The transaction completes on the bus, but if_rvalid is suppressed. Flag clears on return to IDLE.
//    Flush with LSU owner or no transaction has no effect.
//  - Simultaneous if_req and lsu_req are resolved as above. A pending req is only sampled in IDLE.
//  - Writes: lsu_rvalid acknowledges; lsu_rdata is don't-care (drive bus_rdata).
// TESTING
//  1. Single fetch addr 0x80000000, bus_ready same cycle, rvalid 2 cycles later, rdata 0x13 ->
//     if_gnt@T, bus_valid@T+1 only, if_rvalid with 0x13@T+3.
//  2. if_req and lsu_req held continuously, zero-wait bus, STARVE_LIMIT=4 -> grant order L,L,L,L,I,L,L,L,L,I.
//  3. LSU write addr 0x1008, wmask 0xF0, wdata 0xAABB -> bus_wen=1, bus_wmask=0xF0, lsu_rvalid once, if_rvalid never.
//  4. Fetch accepted, if_flush pulsed in RESP -> bus completes, if_rvalid stays 0.
//     Next fetch 0x80000010 returns its own data normally.
//  5. bus_rvalid withheld, TIMEOUT=8 -> owner rvalid with err=1 eight cycles after RESP entry; FSM back in IDLE.
//  6. rst asserted in REQ -> next cycle bus_valid=0, no gnt/rvalid outputs, starve_cnt=0; fresh fetch then works as in test 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one bus port between fetch and LSU.
// LSU has priority; a starvation guard forces fetch through periodically.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                lsu_req,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,
  output logic                bus_valid,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_wen,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wmask,
  input  logic                bus_ready,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_err
);

  localparam int MW = DATA_W / 8;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [7:0]    TMO_MAX    = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic              owner_if_q;
  logic              flushed_q;
  logic [SW-1:0]     starve_q;
  logic [7:0]        tmo_q;
  logic              bus_valid_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic              bus_wen_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [MW-1:0]     bus_wmask_q;

  logic              pick_if;
  logic              in_idle;
  logic              tmo_hit;
  logic              done;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  // Fetch wins only when LSU is absent or LSU has starved it long enough.
  assign pick_if = if_req & (~lsu_req | (starve_q == STARVE_MAX));
  assign in_idle = ~rst & (state_q == IDLE);
  assign if_gnt  = in_idle & pick_if;
  assign lsu_gnt = in_idle & lsu_req & ~pick_if;

  assign tmo_hit   = (tmo_q == TMO_MAX);
  assign done      = ~rst & (state_q == RESP) & (bus_rvalid | tmo_hit);
  assign resp_data = bus_rvalid ? bus_rdata : '0;
  assign resp_err  = bus_rvalid ? bus_err : 1'b1;

  assign if_rvalid  = done & owner_if_q & ~flushed_q & ~if_flush;
  assign lsu_rvalid = done & ~owner_if_q;
  assign if_rdata   = if_rvalid ? resp_data : '0;
  assign if_err     = if_rvalid & resp_err;
  assign lsu_rdata  = lsu_rvalid ? resp_data : '0;
  assign lsu_err    = lsu_rvalid & resp_err;

  assign bus_valid = bus_valid_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wen   = bus_wen_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wmask = bus_wmask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_if_q  <= 1'b0;
      flushed_q   <= 1'b0;
      starve_q    <= '0;
      tmo_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wen_q   <= 1'b0;
      bus_wdata_q <= '0;
      bus_wmask_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (if_req | lsu_req) begin
            state_q     <= REQ;
            bus_valid_q <= 1'b1;
            owner_if_q  <= pick_if;
            flushed_q   <= pick_if & if_flush;
            if (pick_if) begin
              bus_addr_q  <= if_addr;
              bus_wen_q   <= 1'b0;
              bus_wdata_q <= '0;
              bus_wmask_q <= '0;
              starve_q    <= '0;
            end else begin
              bus_addr_q  <= lsu_addr;
              bus_wen_q   <= lsu_wen;
              bus_wdata_q <= lsu_wdata;
              bus_wmask_q <= lsu_wmask;
              if (if_req && starve_q != STARVE_MAX)
                starve_q <= starve_q + 1'b1;
            end
          end
        end
        REQ: begin
          if (if_flush & owner_if_q)
            flushed_q <= 1'b1;
          if (bus_ready) begin
            state_q     <= RESP;
            bus_valid_q <= 1'b0;
            tmo_q       <= '0;
          end
        end
        RESP: begin
          if (if_flush & owner_if_q)
            flushed_q <= 1'b1;
          if (bus_rvalid | tmo_hit) begin
            state_q   <= IDLE;
            flushed_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard.
// The bench plays the bus; expected responses are queued when it answers.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_gnt, if_rvalid, if_err;
  logic [63:0] if_addr, if_rdata;
  logic        lsu_req, lsu_wen, lsu_gnt, lsu_rvalid, lsu_err;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        bus_valid, bus_wen, bus_ready, bus_rvalid, bus_err;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_wmask;

  typedef struct {
    bit          is_if;
    logic [63:0] data;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;
  int n_if_rv = 0;
  int n_lsu_rv = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .if_err(if_err),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wen(bus_wen),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_ready(bus_ready),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every response pulse must match the queue head.
  always @(negedge clk) begin
    if (if_rvalid) n_if_rv++;
    if (lsu_rvalid) n_lsu_rv++;
    if (if_rvalid || lsu_rvalid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", {62'd0, if_rvalid, lsu_rvalid}, 64'd0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        chk("rv_port_if", if_rvalid, e.is_if);
        chk("rv_port_lsu", lsu_rvalid, !e.is_if);
        chk("rv_data", e.is_if ? if_rdata : lsu_rdata, e.data);
        chk("rv_err", e.is_if ? if_err : lsu_err, e.err);
      end
    end
  end

  // One transaction starting in an IDLE cycle with requests already driven.
  task automatic run_xact(input bit exp_if, input logic [63:0] exp_addr,
                          input bit exp_wen, input logic [7:0] exp_wmask,
                          input logic [63:0] exp_wdata,
                          input logic [63:0] rd, input int lat,
                          input bit hold, input bit flush);
    resp_t e;
    @(negedge clk);
    chk("gnt_if", if_gnt, exp_if);
    chk("gnt_lsu", lsu_gnt, !exp_if);
    chk("bus_valid_gnt_cycle", bus_valid, 1'b0);
    step();
    if (!hold) begin
      if (exp_if) if_req = 1'b0;
      else lsu_req = 1'b0;
    end
    bus_ready = 1'b1;
    @(negedge clk);
    chk("bus_valid_req", bus_valid, 1'b1);
    chk("bus_addr", bus_addr, exp_addr);
    chk("bus_wen", bus_wen, exp_wen);
    chk("bus_wmask", bus_wmask, exp_wmask);
    if (exp_wen) chk("bus_wdata", bus_wdata, exp_wdata);
    step();
    bus_ready = 1'b0;
    if_flush = flush;
    for (int k = 1; k < lat; k++) begin
      step();
      if_flush = 1'b0;
    end
    bus_rvalid = 1'b1;
    bus_rdata = rd;
    bus_err = 1'b0;
    if (!(exp_if && flush)) begin
      e.is_if = exp_if;
      e.data = rd;
      e.err = 1'b0;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("bus_valid_resp", bus_valid, 1'b0);
    step();
    bus_rvalid = 1'b0;
    if_flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ifc;
    int lsc;
    resp_t e;
    rst = 1'b1;
    if_req = 0; if_addr = 0; if_flush = 0;
    lsu_req = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
    step();
    step();
    @(negedge clk);
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_bus_addr", bus_addr, 64'd0);
    chk("rst_gnts", {if_gnt, lsu_gnt}, 64'd0);
    chk("rst_rvalids", {if_rvalid, lsu_rvalid}, 64'd0);
    step();
    rst = 1'b0;

    // 1: single fetch, rvalid two cycles after acceptance
    if_req = 1'b1;
    if_addr = 64'h8000_0000;
    run_xact(1'b1, 64'h8000_0000, 1'b0, 8'h00, 64'd0, 64'h13, 2, 1'b0, 1'b0);
    chk("t1_drained", sb.size(), 64'd0);

    // 2: both held, zero-wait bus, starvation guard
    if_req = 1'b1;
    if_addr = 64'h8000_0100;
    lsu_req = 1'b1;
    lsu_addr = 64'h3000;
    lsu_wen = 1'b0;
    lsu_wmask = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4)
        run_xact(1'b1, 64'h8000_0100, 1'b0, 8'h00, 64'd0,
                 64'(100 + i), 1, 1'b1, 1'b0);
      else
        run_xact(1'b0, 64'h3000, 1'b0, 8'hFF, 64'd0,
                 64'(100 + i), 1, 1'b1, 1'b0);
    end
    if_req = 1'b0;
    lsu_req = 1'b0;
    step();
    chk("t2_drained", sb.size(), 64'd0);

    // 3: LSU write
    ifc = n_if_rv;
    lsc = n_lsu_rv;
    lsu_req = 1'b1;
    lsu_addr = 64'h1008;
    lsu_wen = 1'b1;
    lsu_wdata = 64'hAABB;
    lsu_wmask = 8'hF0;
    run_xact(1'b0, 64'h1008, 1'b1, 8'hF0, 64'hAABB, 64'h5555, 2, 1'b0, 1'b0);
    lsu_wen = 1'b0;
    chk("t3_lsu_rv_once", n_lsu_rv - lsc, 64'd1);
    chk("t3_if_rv_never", n_if_rv - ifc, 64'd0);

    // 4: flushed fetch is dropped, next fetch returns normally
    ifc = n_if_rv;
    if_req = 1'b1;
    if_addr = 64'h8000_0008;
    run_xact(1'b1, 64'h8000_0008, 1'b0, 8'h00, 64'd0, 64'hBAD, 2, 1'b0, 1'b1);
    chk("t4_flush_no_rv", n_if_rv - ifc, 64'd0);
    if_req = 1'b1;
    if_addr = 64'h8000_0010;
    run_xact(1'b1, 64'h8000_0010, 1'b0, 8'h00, 64'd0, 64'h77, 2, 1'b0, 1'b0);
    chk("t4_next_rv", n_if_rv - ifc, 64'd1);

    // 5: timeout with bus_rvalid withheld
    lsu_req = 1'b1;
    lsu_addr = 64'h2000;
    @(negedge clk);
    chk("t5_gnt", lsu_gnt, 1'b1);
    step();
    lsu_req = 1'b0;
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    bus_rdata = 64'hDEAD;
    e.is_if = 1'b0;
    e.data = 64'd0;
    e.err = 1'b1;
    sb.push_back(e);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t5_no_rv_early", lsu_rvalid, 1'b0);
      step();
    end
    @(negedge clk);
    chk("t5_timeout_rv", lsu_rvalid, 1'b1);
    step();
    bus_rvalid = 1'b1;
    @(negedge clk);
    chk("t5_stray_ignored", {if_rvalid, lsu_rvalid}, 64'd0);
    step();
    bus_rvalid = 1'b0;
    chk("t5_drained", sb.size(), 64'd0);

    // 6: reset while in REQ abandons the transaction
    if_req = 1'b1;
    if_addr = 64'h8000_0020;
    lsu_req = 1'b1;
    lsu_addr = 64'h4000;
    @(negedge clk);
    chk("t6_gnt_lsu", lsu_gnt, 1'b1);
    step();
    rst = 1'b1;
    if_req = 1'b0;
    lsu_req = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_bus_valid", bus_valid, 1'b0);
    chk("t6_gnts", {if_gnt, lsu_gnt}, 64'd0);
    chk("t6_rvalids", {if_rvalid, lsu_rvalid}, 64'd0);
    chk("t6_starve", 64'(dut.starve_q), 64'd0);
    step();
    if_req = 1'b1;
    if_addr = 64'h8000_0000;
    run_xact(1'b1, 64'h8000_0000, 1'b0, 8'h00, 64'd0, 64'h13, 2, 1'b0, 1'b0);
    step();
    chk("final_drained", sb.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
